// File: rtl/and_gate_bist.sv
// and_gate_bist -- built-in self-test sequencer for one AND gate.
//
// Walks the gate inputs through {A,B} = 00, 01, 10, 11 for ITERATIONS sweeps.
// Each vector is held for max(SETTLE_CYCLES,1) clocks before Y is compared
// against A&B. The run ends with a one-cycle done pulse and a pass flag.
//
// Optional build macro: AND_BIST_STOP_ON_FAIL_EN
//   defined   -> the first mismatch ends the run immediately (pass=0)
//   undefined -> every vector of every sweep is applied and all mismatches
//                are accumulated
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      run request, sampled only in IDLE
//   abort      synchronous abort of a running test
//   A_out      drives gate input A
//   B_out      drives gate input B
//   Y_in       gate output Y
//   busy       high while a vector is settling or being checked
//   done       one-cycle completion pulse
//   pass       result of the last run, held until the next accepted start
//   err_vec    sticky mismatch flag per vector, bit index = {A,B}
//   fail_count saturating mismatch count
module and_gate_bist #(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned ITERATIONS    = 1,
   parameter int unsigned CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic             A_out,
   output logic             B_out,
   input  logic             Y_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [3:0]       err_vec,
   output logic [CNT_W-1:0] fail_count
);

   localparam int unsigned S_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
   localparam int unsigned CW    = (S_EFF > 1) ? $clog2(S_EFF) : 1;
   localparam int unsigned IW    = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(S_EFF - 1);
   localparam logic [IW-1:0] ITER_LAST = IW'(ITERATIONS - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [1:0]       idx, idx_nxt;
   logic [IW-1:0]    iter, iter_nxt;
   logic             a_nxt, b_nxt, busy_nxt, done_nxt, pass_nxt;
   logic [3:0]       err_nxt;
   logic [CNT_W-1:0] fcnt_nxt;

   logic mismatch, last_vec, stop_fail;

   assign mismatch = (Y_in != (A_out & B_out));
   assign last_vec = (idx == 2'd3) && (iter == ITER_LAST);

`ifdef AND_BIST_STOP_ON_FAIL_EN
   assign stop_fail = mismatch;
`else
   assign stop_fail = 1'b0;
`endif

   // State register plus all registered outputs and datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         iter       <= '0;
         A_out      <= 1'b0;
         B_out      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_vec    <= '0;
         fail_count <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         idx        <= idx_nxt;
         iter       <= iter_nxt;
         A_out      <= a_nxt;
         B_out      <= b_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
         pass       <= pass_nxt;
         err_vec    <= err_nxt;
         fail_count <= fcnt_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:   if (start) state_nxt = SETTLE;
         SETTLE: begin
            if (abort)                 state_nxt = DONE;
            else if (cnt == CNT_LAST)  state_nxt = CHECK;
         end
         CHECK:  begin
            if (abort || last_vec || stop_fail) state_nxt = DONE;
            else                                state_nxt = SETTLE;
         end
         DONE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of the registered outputs. The CHECK comparison is recorded
   // even when the run ends in that cycle, so pass is derived from the
   // updated count rather than the current one.
   always_comb begin
      cnt_nxt  = cnt;
      idx_nxt  = idx;
      iter_nxt = iter;
      a_nxt    = A_out;
      b_nxt    = B_out;
      done_nxt = 1'b0;
      pass_nxt = pass;
      err_nxt  = err_vec;
      fcnt_nxt = fail_count;
      busy_nxt = (state_nxt == SETTLE) || (state_nxt == CHECK);

      unique case (state)
         IDLE: begin
            a_nxt = 1'b0;
            b_nxt = 1'b0;
            if (start) begin
               pass_nxt = 1'b0;
               err_nxt  = '0;
               fcnt_nxt = '0;
               idx_nxt  = '0;
               iter_nxt = '0;
               cnt_nxt  = '0;
            end
         end
         SETTLE: begin
            cnt_nxt = cnt + CW'(1);
            if (abort) begin
               a_nxt    = 1'b0;
               b_nxt    = 1'b0;
               done_nxt = 1'b1;
               pass_nxt = 1'b0;
            end
         end
         CHECK: begin
            if (mismatch) begin
               err_nxt[idx] = 1'b1;
               if (fail_count != '1) fcnt_nxt = fail_count + CNT_W'(1);
            end
            if (state_nxt == DONE) begin
               a_nxt    = 1'b0;
               b_nxt    = 1'b0;
               done_nxt = 1'b1;
               pass_nxt = (fcnt_nxt == '0) && !abort;
            end else begin
               idx_nxt = idx + 2'd1;
               if (idx == 2'd3) iter_nxt = iter + IW'(1);
               a_nxt   = idx_nxt[1];
               b_nxt   = idx_nxt[0];
               cnt_nxt = '0;
            end
         end
         DONE: begin
            a_nxt = 1'b0;
            b_nxt = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/and_gate_bist.md
Name: and_gate_bist

Overview:
- Built-in self-test sequencer for a single AND_GATE instance.
- Drives the gate's A/B inputs through the full truth table and samples Y after a programmable settle time.
- Compares Y against A&B and reports pass/fail, per-vector error flags and a mismatch count.
- Sits beside the gate in the test/bring-up wrapper and owns the gate's inputs while busy.

Parameters:
SETTLE_CYCLES, 1, clocks between applying a vector and sampling Y; 0 is treated as 1
ITERATIONS, 1, number of full 4-vector sweeps per run; must be >= 1
CNT_W, 8, width of fail_count

Ports:
clk  input  1  single clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  run request, sampled only in IDLE
abort  input  1  synchronous abort of a running test
A_out  output  1  drives gate input A
B_out  output  1  drives gate input B
Y_in  input  1  gate output Y
busy  output  1  high in SETTLE and CHECK
done  output  1  one-cycle completion pulse
pass  output  1  result of last run; held until the next accepted start
err_vec  output  4  sticky mismatch flag per vector; bit index = {A,B}
fail_count  output  CNT_W  saturating mismatch count

Behaviour:
- Reset (async, rst_n=0): state=IDLE; A_out, B_out, busy, done, pass, err_vec and fail_count all 0. Applies at any time, including mid-run; no partial result survives.
- States: IDLE, SETTLE, CHECK, DONE. All outputs are registered.
- IDLE:
  - start=1 accepted: pass<=0, err_vec<=0, fail_count<=0, vector idx<=0, iter<=0, settle cnt<=0, {A_out,B_out}<=2'b00, go to SETTLE.
  - start=0: A_out=B_out=0.
- SETTLE: cnt increments each clock; go to CHECK on the edge where cnt==max(SETTLE_CYCLES,1)-1.
- CHECK: compare Y_in against A_out&B_out.
  - On mismatch: err_vec[idx]<=1 and fail_count+=1, saturating at all-ones.
  - If idx==3 and iter==ITERATIONS-1, go to DONE.
  - Otherwise idx<=idx+1 (wraps 3->0, and iter+=1 on the wrap), load the next vector onto A_out/B_out, cnt<=0, go to SETTLE.
- Vector order: 00, 01, 10, 11 as {A,B}; expected Y = 0, 0, 0, 1.
- DONE: done=1 for exactly one cycle; pass = (fail_count==0 and not aborted); A_out=B_out=0; next state is IDLE. start during DONE is ignored.
- Latency: done is high in the cycle after edge N, where N = 4*ITERATIONS*(max(SETTLE_CYCLES,1)+1) counted from the edge that accepted start. Default parameters give N=8.
- abort=1 in SETTLE or CHECK: go to DONE on the next edge with pass forced to 0. The CHECK comparison in the abort cycle is still recorded. abort is ignored in IDLE and DONE.
- abort and start together in IDLE: start wins; the abort is ignored.
- fail_count, err_vec and pass hold their values in IDLE until the next accepted start.

Optional Feature:
AND_BIST_STOP_ON_FAIL_EN
- Defined: the first mismatch in CHECK goes directly to DONE with pass=0. err_vec holds exactly one set bit and fail_count=1.
- Undefined: the run always completes every vector of every iteration and accumulates all mismatches.

Test Plan:
- Good gate, defaults; pulse start once -> A_out/B_out step 00, 01, 10, 11, two cycles each; done high after edge 8; pass=1, err_vec=0, fail_count=0.
- Gate model stuck-at-1 on Y, ITERATIONS=2 -> err_vec=4'b0111, fail_count=6, pass=0; done after edge 16.
- SETTLE_CYCLES=3, gate with 2-cycle output delay -> pass=1. SETTLE_CYCLES=1 on the same gate -> at least one err_vec bit set, pass=0.
- Assert abort in the CHECK cycle of vector 01 -> done the next cycle, pass=0, A_out=B_out=0. A new start then runs cleanly to pass=1.
- Deassert rst_n during SETTLE of vector 10 -> all outputs 0 immediately, before any clock edge; after release, state is IDLE and start is accepted.
- With AND_BIST_STOP_ON_FAIL_EN defined and Y stuck-at-0 -> vector 11 fails; err_vec=4'b1000, fail_count=1, pass=0; done after edge 8.
